// File: rtl/axi_config_wr_pkg.sv
// Shared encodings for the AXI config register write/read slaves:
// FSM states, BRESP codes and AXI burst types.
package axi_config_wr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

endpackage

// File: rtl/axi_config_wr.sv
// AXI4 write slave: one burst at a time, one registered register-write strobe per W beat,
// one B response per burst. All outputs registered; W beats are counted, wlast only flags errors.
module axi_config_wr
  import axi_config_wr_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int ID_WIDTH     = 8,
  parameter int AWUSER_WIDTH = 1,
  parameter int BUSER_WIDTH  = 1,
  parameter int ADDR_INCR    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic [3:0]              s_axi_awregion,
  input  logic [AWUSER_WIDTH-1:0] s_axi_awuser,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]   s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic [BUSER_WIDTH-1:0]  s_axi_buser,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic                    wr,
  output logic [ADDR_WIDTH-1:0]   waddr,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [STRB_WIDTH-1:0]   wstrb
);

  state_t                state, state_nxt;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            cnt_q;
  logic                  fixed_q;
  logic                  err_q;
  logic                  aw_hs, w_hs, b_hs, last_beat, beat_err;
  logic                  unused_sideband;

  assign unused_sideband = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                             s_axi_awqos, s_axi_awregion, s_axi_awuser};

  assign s_axi_buser = '0;
  assign aw_hs       = s_axi_awvalid & s_axi_awready;
  assign w_hs        = s_axi_wvalid & s_axi_wready;
  assign b_hs        = s_axi_bvalid & s_axi_bready;
  assign last_beat   = (cnt_q == 8'd0);
  // wlast must be high exactly on the counted final beat
  assign beat_err    = s_axi_wlast ^ last_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (aw_hs) state_nxt = DATA;
      DATA:    if (w_hs && last_beat) state_nxt = RESP;
      RESP:    if (b_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake readies and bvalid are registered copies of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= BRESP_OKAY;
      wr            <= 1'b0;
      waddr         <= '0;
      wdata         <= '0;
      wstrb         <= '0;
      id_q          <= '0;
      addr_q        <= '0;
      cnt_q         <= '0;
      fixed_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      s_axi_awready <= (state_nxt == IDLE);
      s_axi_wready  <= (state_nxt == DATA);
      s_axi_bvalid  <= (state_nxt == RESP);
      wr            <= w_hs;
      if (aw_hs) begin
        id_q    <= s_axi_awid;
        addr_q  <= s_axi_awaddr;
        cnt_q   <= s_axi_awlen;
        fixed_q <= (s_axi_awburst == BURST_FIXED);
        // WRAP and reserved bursts are written with INCR addressing but answered SLVERR
        err_q   <= (s_axi_awburst == BURST_WRAP) || (s_axi_awburst == BURST_RSVD);
      end
      if (w_hs) begin
        waddr <= addr_q;
        wdata <= s_axi_wdata;
        wstrb <= s_axi_wstrb;
        cnt_q <= cnt_q - 8'd1;
        err_q <= err_q | beat_err;
        if (!fixed_q) addr_q <= addr_q + ADDR_WIDTH'(ADDR_INCR);
        if (last_beat) begin
          s_axi_bid   <= id_q;
          s_axi_bresp <= (err_q | beat_err) ? BRESP_SLVERR : BRESP_OKAY;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_config_wr.sv
// Table of bursts driven through axi_config_wr; register writes checked against a queue
// of expectations pushed at each W handshake, plus hand sequences for reset abort and B stalls.
module tb_axi_config_wr;
  import axi_config_wr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_axi_awid = '0;
  logic [31:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = 3'd2;
  logic [1:0]  s_axi_awburst = '0;
  logic        s_axi_awlock = 1'b0;
  logic [3:0]  s_axi_awcache = '0;
  logic [2:0]  s_axi_awprot = '0;
  logic [3:0]  s_axi_awqos = '0;
  logic [3:0]  s_axi_awregion = '0;
  logic [0:0]  s_axi_awuser = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [7:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic [0:0]  s_axi_buser;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic        wr;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  axi_config_wr dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
    .s_axi_awregion(s_axi_awregion), .s_axi_awuser(s_axi_awuser),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_buser(s_axi_buser),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .wr(wr), .waddr(waddr), .wdata(wdata), .wstrb(wstrb)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_exp_t;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [15:0] last_mask;
    bit          gap;
    int          hold;
    logic [1:0]  resp;
  } burst_rec_t;

  wr_exp_t    exp_q[$];
  burst_rec_t tbl[9];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr === 1'b1) begin
      wr_exp_t e;
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("waddr", waddr, e.addr);
        check("wdata", wdata, e.data);
        check("wstrb", wstrb, e.strb);
      end
    end
  end

  // All driver tasks start and end on a falling edge.
  task automatic aw_send(input logic [7:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
    if (!s_axi_awready) check("aw_timeout", 64'd0, 64'd1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] exp_addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic last);
    int n = 0;
    wr_exp_t e;
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
    while (!s_axi_wready && n < 50) begin @(negedge clk); n++; end
    if (!s_axi_wready) begin
      check("w_timeout", 64'd0, 64'd1);
      return;
    end
    e.addr = exp_addr; e.data = data; e.strb = strb;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic b_recv(input logic [7:0] id, input logic [1:0] resp, input int hold);
    int n = 0;
    while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
    check("bvalid_seen", s_axi_bvalid, 1);
    check("bid", s_axi_bid, id);
    check("bresp", s_axi_bresp, resp);
    check("buser", s_axi_buser, 0);
    check("awready_in_resp", s_axi_awready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bvalid_hold", s_axi_bvalid, 1);
      check("bid_hold", s_axi_bid, id);
      check("bresp_hold", s_axi_bresp, resp);
      check("awready_hold", s_axi_awready, 0);
    end
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    check("bvalid_clear", s_axi_bvalid, 0);
    check("awready_after_b", s_axi_awready, 1);
  endtask

  task automatic run_burst(input burst_rec_t r);
    int start_cnt = wr_cnt;
    logic [31:0] a;
    aw_send(r.id, r.addr, r.len, r.burst);
    check("wready_after_aw", s_axi_wready, 1);
    for (int i = 0; i <= int'(r.len); i++) begin
      if (r.gap && i > 0) begin
        s_axi_wvalid = 1'b0;
        @(negedge clk);
        check("wr_gap", wr, 0);
      end
      a = r.addr + ((r.burst == BURST_FIXED) ? 32'd0 : 32'(4 * i));
      w_beat(a, r.data + 32'(i), r.strb, r.last_mask[i]);
      check("wr_latency", wr, 1);
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast = 1'b0;
    check("bvalid_with_last_wr", s_axi_bvalid, 1);
    check("wready_drop", s_axi_wready, 0);
    b_recv(r.id, r.resp, r.hold);
    check("wr_count", 64'(wr_cnt - start_cnt), 64'(int'(r.len) + 1));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    burst_rec_t single8;
    //            id     addr          len   burst        data          strb  lastmask gap hold resp
    tbl[0] = '{8'h05, 32'h0000_0100, 8'd0, BURST_INCR,  32'hDEAD_BEEF, 4'hF, 16'h1, 0, 0, BRESP_OKAY};
    tbl[1] = '{8'h11, 32'h0000_0040, 8'd3, BURST_INCR,  32'h1,         4'hF, 16'h8, 0, 0, BRESP_OKAY};
    tbl[2] = '{8'h22, 32'h0000_0040, 8'd3, BURST_INCR,  32'h1,         4'hF, 16'h8, 1, 5, BRESP_OKAY};
    tbl[3] = '{8'h03, 32'h0000_0020, 8'd2, BURST_FIXED, 32'hA0,        4'h3, 16'h4, 0, 0, BRESP_OKAY};
    tbl[4] = '{8'h04, 32'h0000_0000, 8'd1, BURST_WRAP,  32'hB0,        4'hF, 16'h2, 0, 0, BRESP_SLVERR};
    tbl[5] = '{8'h06, 32'h0000_0080, 8'd2, BURST_INCR,  32'hC0,        4'hF, 16'h5, 0, 1, BRESP_SLVERR};
    tbl[6] = '{8'h07, 32'hFFFF_FFFC, 8'd1, BURST_INCR,  32'hD0,        4'h0, 16'h2, 1, 0, BRESP_OKAY};
    tbl[7] = '{8'h08, 32'h0000_0300, 8'd0, BURST_RSVD,  32'hE0,        4'hF, 16'h1, 0, 0, BRESP_SLVERR};
    tbl[8] = '{8'hFF, 32'h0000_0400, 8'd1, BURST_INCR,  32'hF0,        4'hC, 16'h0, 0, 2, BRESP_SLVERR};
    single8 = '{8'h09, 32'h0000_0008, 8'd0, BURST_INCR, 32'h1234_5678, 4'hF, 16'h1, 0, 0, BRESP_OKAY};

    #1;
    check("rst_awready", s_axi_awready, 0);
    check("rst_wready", s_axi_wready, 0);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_wr", wr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("awready_before_edge", s_axi_awready, 0);
    @(negedge clk);
    check("awready_after_rst", s_axi_awready, 1);

    for (int t = 0; t < 9; t++) run_burst(tbl[t]);

    // Abort a 4-beat burst after two beats with an asynchronous reset.
    aw_send(8'h33, 32'h0000_0200, 8'd3, BURST_INCR);
    w_beat(32'h0000_0200, 32'h55, 4'hF, 1'b0);
    w_beat(32'h0000_0204, 32'h56, 4'hF, 1'b0);
    s_axi_wvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort_awready", s_axi_awready, 0);
    check("abort_wready", s_axi_wready, 0);
    check("abort_bvalid", s_axi_bvalid, 0);
    check("abort_bid", s_axi_bid, 0);
    check("abort_bresp", s_axi_bresp, 0);
    check("abort_wr", wr, 0);
    check("abort_waddr", waddr, 0);
    check("abort_wdata", wdata, 0);
    check("abort_wstrb", wstrb, 0);
    @(negedge clk);
    @(negedge clk);
    check("abort_no_bvalid", s_axi_bvalid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_awready_back", s_axi_awready, 1);
    check("abort_no_bvalid_after", s_axi_bvalid, 0);
    check("abort_queue_empty", 64'(exp_q.size()), 64'd0);
    run_burst(single8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
